delay_timer: RTL and testbench
==============================

DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 SHALL have parameter DELAY_W, default 4, width of the shifted-in delay value.
REQ-002 SHALL have parameter TICKS_PER_UNIT, default 1000, clk cycles per delay unit.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data  input  1  serial delay bit, MSB first.
REQ-007 SHALL have port shift_ena  input  1  from upstream detector FSM; shift data in.
REQ-008 SHALL have port counting  input  1  from upstream FSM; run the timer.
REQ-009 SHALL have port done_counting  output  1  timer expired, to upstream FSM.
REQ-010 SHALL have port count  output  DELAY_W  remaining delay units.
REQ-011 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement states IDLE, LOAD, RUN, EXPIRED.
REQ-013 SHALL, on any cycle with shift_ena=1 in IDLE/LOAD, register delay <= {delay[DELAY_W-2:0], data} and go to LOAD.
REQ-014 SHALL, on counting=1 in IDLE/LOAD, load the remaining-units counter from delay, clear the tick counter and go to RUN.
REQ-015 SHALL, in RUN, increment the tick counter each cycle and wrap it to 0 at TICKS_PER_UNIT-1.
REQ-016 SHALL, on a tick wrap with remaining>0, decrement remaining by 1.
REQ-017 SHALL, on a tick wrap with remaining=0, go to EXPIRED and register done_counting=1.
REQ-018 SHALL give done_counting=1 exactly (delay+1)*TICKS_PER_UNIT edges after the edge at which counting was first sampled high.
REQ-019 SHALL hold done_counting=1 in EXPIRED while counting=1, and return to IDLE with done_counting=0 on the edge after counting=0 is sampled.
REQ-020 SHALL drive count as follows: the delay register in IDLE/LOAD, remaining in RUN, 0 in EXPIRED.
REQ-021 SHALL, if counting drops in RUN, abort to IDLE without asserting done_counting.
REQ-022 SHALL give shift_ena priority when shift_ena and counting are both 1; counting is ignored that cycle and proto_err is set.
REQ-023 SHALL ignore shift_ena in RUN/EXPIRED and set proto_err.
REQ-024 SHALL leave the delay register unchanged by counting, so an identical count can be rerun without reshifting.
REQ-025 SHALL handle the delay=2^DELAY_W-1 boundary with no overflow: 16000 cycles at defaults.

Reset
REQ-026 SHALL, while reset_n=0, force the state to IDLE and set delay=0, remaining=0, tick=0, done_counting=0, count=0 and proto_err=0.
REQ-027 SHALL clear proto_err by reset only.
REQ-028 SHALL abort any RUN/EXPIRED activity when reset is asserted mid-operation, with no done_counting glitch on release.

Configuration
REQ-029 SHALL support macro DELAY_TIMER_FAST_SIM_EN; when defined, the effective ticks per unit is 4, ignoring TICKS_PER_UNIT.
REQ-030 SHALL use TICKS_PER_UNIT ticks per unit when DELAY_TIMER_FAST_SIM_EN is undefined.

Structure
REQ-031 SHALL place the state enum (2-bit) and the FAST_SIM tick constant in package delay_timer_pkg.
REQ-032 SHALL implement the tick counter as sub-module tick_prescaler (enable, clear, wrap pulse out), with width $clog2 of the effective ticks per unit.

Verification
REQ-033 SHALL cover: shift 4'b0010 with shift_ena=1 for 4 cycles, then counting=1 -> done_counting rises 3000 cycles later; count steps 2,1,0.
REQ-034 SHALL cover: delay=4'b1111 -> done_counting at 16000 cycles; count never wraps above 15.
REQ-035 SHALL cover: counting dropped after 500 cycles of RUN -> IDLE, done_counting stays 0, count shows the delay.
REQ-036 SHALL cover: shift_ena and counting both high in LOAD -> bit shifted, state LOAD, proto_err=1 until reset.
REQ-037 SHALL cover: reset_n pulsed low mid-RUN -> all outputs 0 asynchronously, IDLE after release.
REQ-038 SHALL cover: with DELAY_TIMER_FAST_SIM_EN and delay=0 -> done_counting 4 cycles after counting is sampled.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay timer.
// The 2-bit state encoding and the fast-simulation tick count both live here.
// This lets the top level and any test code agree on the same values.
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Ticks per unit used when the fast-simulation build is selected.
    localparam int FAST_SIM_TICKS = 4;

    // Counter width for a given tick count. It never drops below one bit.
    function automatic int tick_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_tick_prescaler.sv
// Tick prescaler for the delay timer.
// It divides clk down to one wrap pulse per delay unit.
// The counter runs while enable is high and returns to zero when clear is high.
// wrap is combinational: it is high on the cycle whose edge takes the counter back to 0.
module tick_prescaler
    import delay_timer_pkg::*;
#(
    parameter int TICKS = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int TICK_W = tick_width(TICKS);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS - 1);

    logic [TICK_W-1:0] tick;

    assign wrap = enable && (tick == LAST_TICK);

    // Count clk cycles within one delay unit, wrapping at TICKS-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick <= '0;
        end else if (clear) begin
            tick <= '0;
        end else if (enable) begin
            tick <= (tick == LAST_TICK) ? '0 : tick + 1'b1;
        end
    end

endmodule

// File: rtl/delay_timer.sv
// Programmable delay timer that works alongside an upstream detector FSM.
// The delay is shifted in serially, MSB first, while shift_ena is high.
// While counting is high, the timer runs for (delay+1) units and then raises done_counting.
// proto_err is sticky. It records shift_ena seen outside IDLE/LOAD, or shift_ena and counting high together.
// Optional build macro: DELAY_TIMER_FAST_SIM_EN. When defined, a unit is 4 clk cycles.
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int DELAY_W        = 4,
    parameter int TICKS_PER_UNIT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data,
    input  logic               shift_ena,
    input  logic               counting,
    output logic               done_counting,
    output logic [DELAY_W-1:0] count,
    output logic               proto_err
);

`ifdef DELAY_TIMER_FAST_SIM_EN
    localparam int EFF_TICKS = FAST_SIM_TICKS;
`else
    localparam int EFF_TICKS = TICKS_PER_UNIT;
`endif

    state_t             state;
    state_t             state_next;
    logic [DELAY_W-1:0] delay_value;
    logic [DELAY_W-1:0] remaining;
    logic               done_reg;
    logic               err_reg;
    logic               do_shift;
    logic               do_start;
    logic               do_dec;
    logic               set_err;
    logic               tick_en;
    logic               tick_clear;
    logic               wrap;

    // Ticks only advance in RUN with counting held. In every other state the counter is held at zero.
    assign tick_en    = (state == RUN) && counting;
    assign tick_clear = (state != RUN);

    tick_prescaler #(
        .TICKS (EFF_TICKS)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tick_en),
        .clear   (tick_clear),
        .wrap    (wrap)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes. When shift_ena and counting are both high, the shift wins.
    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        do_start   = 1'b0;
        do_dec     = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (shift_ena) begin
                    do_shift   = 1'b1;
                    state_next = LOAD;
                    set_err    = counting;
                end else if (counting) begin
                    do_start   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                set_err = shift_ena;
                if (!counting) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    if (remaining != '0) begin
                        do_dec = 1'b1;
                    end else begin
                        state_next = EXPIRED;
                    end
                end
            end
            EXPIRED: begin
                set_err = shift_ena;
                if (!counting) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay register, remaining-units counter, done flag and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_value <= '0;
            remaining   <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (do_shift) begin
                delay_value <= {delay_value[DELAY_W-2:0], data};
            end
            if (do_start) begin
                remaining <= delay_value;
            end else if (do_dec) begin
                remaining <= remaining - 1'b1;
            end
            done_reg <= (state_next == EXPIRED);
            if (set_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    // count shows the programmed delay while idle or loading, the remaining units while running, and zero once expired.
    always_comb begin
        count = '0;
        case (state)
            IDLE, LOAD: count = delay_value;
            RUN:        count = remaining;
            default:    count = '0;
        endcase
    end

    assign done_counting = done_reg;
    assign proto_err     = err_reg;

endmodule

// File: tb/tb_delay_timer.sv
// Directed testbench for delay_timer. Every expected value is worked out by hand.
// Timing uses the same unit length as the DUT build. Unit length is 4 when DELAY_TIMER_FAST_SIM_EN is defined, otherwise 1000.
module tb_delay_timer;

    localparam int DW = 4;
`ifdef DELAY_TIMER_FAST_SIM_EN
    localparam int TPU = 4;
`else
    localparam int TPU = 1000;
`endif
    localparam int ABORT_N = TPU / 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          data;
    logic          shift_ena;
    logic          counting;
    logic          done_counting;
    logic [DW-1:0] count;
    logic          proto_err;

    int checks = 0;
    int passed = 0;

    delay_timer #(
        .DELAY_W        (DW),
        .TICKS_PER_UNIT (1000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data          (data),
        .shift_ena     (shift_ena),
        .counting      (counting),
        .done_counting (done_counting),
        .count         (count),
        .proto_err     (proto_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and record the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then let the DUT sample them.
    task automatic applyStimulus(input logic sh, input logic d, input logic cnt);
        shift_ena = sh;
        data      = d;
        counting  = cnt;
        tick();
    endtask

    // Shift a 4-bit delay into the DUT, MSB first.
    task automatic shiftIn(input logic [DW-1:0] value);
        for (int i = DW - 1; i >= 0; i--) applyStimulus(1'b1, value[i], 1'b0);
        shift_ena = 1'b0;
    endtask

    // Hold counting high until done_counting rises or the budget runs out.
    // n counts edges after the edge that first samples counting, which is n = 0.
    task automatic runTimer(input int budget, output int latency, output int c_first,
                            output int c_pre, output int c_wrap1, output int c_wrap2, output bit grew);
        int prev;
        shift_ena = 1'b0;
        counting  = 1'b1;
        latency = -1; c_first = -1; c_pre = -1; c_wrap1 = -1; c_wrap2 = -1;
        grew = 1'b0; prev = 1 << DW;
        for (int n = 0; n <= budget; n++) begin
            tick();
            if (int'(count) > prev) grew = 1'b1;
            prev = int'(count);
            if (n == 0)       c_first = int'(count);
            if (n == TPU - 1) c_pre   = int'(count);
            if (n == TPU)     c_wrap1 = int'(count);
            if (n == 2 * TPU) c_wrap2 = int'(count);
            if (done_counting === 1'b1) begin
                latency = n;
                break;
            end
        end
    endtask

    initial begin
        int  lat, cf, cp, cw1, cw2;
        bit  grew;
        bit  early_done;

        reset_n = 1'b0; data = 1'b0; shift_ena = 1'b0; counting = 1'b0;
        tick(); tick();
        checkOutput("reset_done", done_counting, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_err", proto_err, 0);
        reset_n = 1'b1;
        tick();

        // Delay 2: done after 3 units, and count steps 2, 1, 0.
        shiftIn(4'b0010);
        checkOutput("load_count", count, 2);
        runTimer(20 * TPU, lat, cf, cp, cw1, cw2, grew);
        checkOutput("d2_latency", lat, 3 * TPU);
        checkOutput("d2_count_start", cf, 2);
        checkOutput("d2_count_pre_wrap", cp, 2);
        checkOutput("d2_count_wrap1", cw1, 1);
        checkOutput("d2_count_wrap2", cw2, 0);
        checkOutput("d2_count_expired", count, 0);
        tick(); tick();
        checkOutput("d2_done_hold", done_counting, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("d2_done_clear", done_counting, 0);
        checkOutput("d2_count_idle", count, 2);

        // The same delay runs again without being shifted in a second time.
        runTimer(20 * TPU, lat, cf, cp, cw1, cw2, grew);
        checkOutput("rerun_latency", lat, 3 * TPU);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Maximum delay: 16 units, and count never climbs.
        shiftIn(4'b1111);
        runTimer(20 * TPU, lat, cf, cp, cw1, cw2, grew);
        checkOutput("d15_latency", lat, 16 * TPU);
        checkOutput("d15_count_start", cf, 15);
        checkOutput("d15_count_monotonic", grew, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Abort part-way through RUN: done never rises and count returns to the delay.
        early_done = 1'b0;
        counting = 1'b1;
        for (int n = 0; n < ABORT_N; n++) begin
            tick();
            if (done_counting !== 1'b0) early_done = 1'b1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        if (done_counting !== 1'b0) early_done = 1'b1;
        tick(); tick();
        if (done_counting !== 1'b0) early_done = 1'b1;
        checkOutput("abort_done_low", early_done, 0);
        checkOutput("abort_count", count, 15);
        checkOutput("abort_err_clean", proto_err, 0);

        // shift_ena and counting high together: the shift wins, the FSM stays in LOAD, and proto_err sets.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("conflict_count", count, 14);
        checkOutput("conflict_err", proto_err, 1);
        checkOutput("conflict_done", done_counting, 0);
        runTimer(20 * TPU, lat, cf, cp, cw1, cw2, grew);
        checkOutput("conflict_latency", lat, 15 * TPU);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("err_sticky", proto_err, 1);

        // Reset pulsed during RUN: outputs clear at once, without waiting for a clock edge.
        counting = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_done", done_counting, 0);
        checkOutput("async_rst_count", count, 0);
        checkOutput("async_rst_err", proto_err, 0);
        counting = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_count", count, 0);
        checkOutput("post_rst_done", done_counting, 0);

        // Delay 0 after reset: done after exactly one unit.
        runTimer(20 * TPU, lat, cf, cp, cw1, cw2, grew);
        checkOutput("d0_latency", lat, TPU);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // shift_ena during RUN is ignored except that it sets proto_err.
        shiftIn(4'b0001);
        counting = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("run_shift_err", proto_err, 1);
        checkOutput("run_shift_count", count, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("run_shift_delay_kept", count, 1);
        checkOutput("run_shift_done", done_counting, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
